// File: rtl/periph_reg_arbiter_if.sv
// Bus bundle between XBAR_PERIPH_BUS requesters, the round-robin arbiter and a
// single register_interface target.
interface periph_reg_arbiter_if #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned BW     = 8,
  parameter int unsigned IW     = 1
);
  localparam int unsigned SW = DW / BW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          valid;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          error;
    logic          ready;
  } rsp_t;

  logic [NumReq-1:0]         req;
  logic [NumReq-1:0][AW-1:0] add;
  logic [NumReq-1:0]         wen;
  logic [NumReq-1:0][DW-1:0] wdata;
  logic [NumReq-1:0][SW-1:0] be;
  logic [NumReq-1:0][IW-1:0] id;
  logic [NumReq-1:0]         gnt;
  logic [NumReq-1:0]         r_valid;
  logic [DW-1:0]             r_rdata;
  logic                      r_opc;
  logic [IW-1:0]             r_id;
  req_t                      reg_req;
  rsp_t                      reg_rsp;

  // master = requesters plus register target (the environment), slave = arbiter
  modport master (
    output req, add, wen, wdata, be, id, reg_rsp,
    input  gnt, r_valid, r_rdata, r_opc, r_id, reg_req
  );

  modport slave (
    input  req, add, wen, wdata, be, id, reg_rsp,
    output gnt, r_valid, r_rdata, r_opc, r_id, reg_req
  );
endinterface

// File: rtl/periph_reg_arbiter.sv
// Round-robin arbiter sharing one register_interface target between NumReq
// periph requesters; grant is locked while the target stalls.
//
// state | meaning
// IDLE  | arbitrate from rr_ptr_q, grant immediately if target is ready
// LOCK  | target stalled, hold the transfer of requester sel_q until ready
module periph_reg_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned BW     = 8,
  parameter int unsigned IW     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  periph_reg_arbiter_if.slave  bus
);
  localparam int unsigned SelW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned SW   = DW / BW;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e            state_q;
  logic [SelW-1:0]   rr_ptr_q;
  logic [SelW-1:0]   sel_q;
  logic [SelW-1:0]   sel_arb;
  logic [SelW-1:0]   sel_cur;
  logic [SelW-1:0]   sel_nxt;
  logic              any_req;
  logic              req_vld;
  logic              ready;
  logic [NumReq-1:0] gnt;
  logic [AW+DW+SW:0] payload;

  // Walk from the highest offset down so the nearest set request after rr_ptr_q wins.
  always_comb begin
    sel_arb = rr_ptr_q;
    for (int i = NumReq - 1; i >= 0; i--) begin
      int unsigned idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (bus.req[idx]) sel_arb = SelW'(idx);
    end
  end

  always_comb begin
    any_req = |bus.req;
    ready   = bus.reg_rsp.ready;
    sel_cur = (state_q == LOCK) ? sel_q : sel_arb;
    req_vld = (state_q == LOCK) ? bus.req[sel_q] : any_req;
    sel_nxt = (sel_cur == SelW'(NumReq - 1)) ? '0 : sel_cur + 1'b1;
    gnt     = '0;
    if (req_vld && ready) gnt[sel_cur] = 1'b1;
  end

  assign payload     = {bus.add[sel_cur], ~bus.wen[sel_cur], bus.wdata[sel_cur], bus.be[sel_cur]};
  assign bus.reg_req = {payload, req_vld};
  assign bus.gnt     = gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            if (ready) begin
              rr_ptr_q <= sel_nxt;
            end else begin
              sel_q   <= sel_arb;
              state_q <= LOCK;
            end
          end
        end
        LOCK: begin
          // A requester withdrawing mid-lock is abandoned without a grant.
          if (!bus.req[sel_q]) begin
            state_q <= IDLE;
          end else if (ready) begin
            rr_ptr_q <= sel_nxt;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.r_valid <= '0;
      bus.r_rdata <= '0;
      bus.r_opc   <= 1'b0;
      bus.r_id    <= '0;
    end else begin
      bus.r_valid <= gnt;
      bus.r_rdata <= bus.reg_rsp.rdata;
      bus.r_opc   <= bus.reg_rsp.error;
      bus.r_id    <= bus.id[sel_cur];
    end
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(bus.gnt));
  a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(bus.r_valid));
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_vld && !ready) |=> (!req_vld || $stable(payload)));
  a_lock_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCK) |-> bus.req[sel_q]);
endmodule
